// File: rtl/register_file.sv
// register_file: Y86-64 architectural register file for the SEQ core.
// Two combinational read ports (valA/valB) plus a debug read port, and two
// write ports (E and M) committed at the rising clock edge.
// Register ID 4'hF is the null register: it reads as zero and never writes.
// When both write ports target the same register, the M port wins (popq %rsp).
// Optional build macro: REGFILE_BYPASS_EN
//   Defined   -> reads forward a write that is pending this cycle, with the
//                M port taking priority over the E port. Intended for a
//                pipelined core.
//   Undefined -> reads return the stored array value only. A register written
//                this cycle shows its new value after the edge.
module register_file #(
  parameter int         DATA_W = 64,
  parameter int         NREGS  = 15,
  parameter logic [3:0] RNONE  = 4'hF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [3:0]        srcA,
  input  logic [3:0]        srcB,
  input  logic [3:0]        dstE,
  input  logic [3:0]        dstM,
  input  logic [DATA_W-1:0] valE,
  input  logic [DATA_W-1:0] valM,
  output logic [DATA_W-1:0] valA,
  output logic [DATA_W-1:0] valB,
  input  logic [3:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_val
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  // Select one stored register by ID. The null ID and any ID with no
  // matching register both read as zero.
  function automatic logic [DATA_W-1:0] array_read(input logic [3:0] id);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (id != RNONE && id == 4'(i)) begin
        r = regs_q[i];
      end
    end
    return r;
  endfunction

`ifdef REGFILE_BYPASS_EN
  // Forward a write that commits at the coming edge. Reset and wr_en gate
  // the write, so they gate the forwarding as well.
  function automatic logic [DATA_W-1:0] read_port(input logic [3:0] id);
    logic [DATA_W-1:0] r;
    r = array_read(id);
    if (!reset && wr_en && id != RNONE) begin
      if (dstM == id) begin
        r = valM;
      end else if (dstE == id) begin
        r = valE;
      end
    end
    return r;
  endfunction
`else
  // Plain array read with no forwarding. This matches single-cycle SEQ timing.
  function automatic logic [DATA_W-1:0] read_port(input logic [3:0] id);
    return array_read(id);
  endfunction
`endif

  // Next-state value of every register. The M write is applied after the
  // E write, so M wins when both ports target the same register.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_en) begin
        if (dstE != RNONE && dstE == 4'(i)) begin
          regs_d[i] = valE;
        end
        if (dstM != RNONE && dstM == 4'(i)) begin
          regs_d[i] = valM;
        end
      end
    end
  end

  // Register array update. A synchronous reset clears every register and
  // drops any write from the same cycle.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREGS; i++) begin
      if (reset) begin
        regs_q[i] <= '0;
      end else begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Combinational read ports, including the debug port.
  always_comb begin
    valA    = read_port(srcA);
    valB    = read_port(srcB);
    dbg_val = read_port(dbg_sel);
  end

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: bench for register_file.
// It runs a vector table, a reset sweep, same-cycle read/write sequences and
// a mid-run reset. Expected values go into a scoreboard queue when stimulus
// is driven and are popped when the outputs are sampled.
module tb_register_file;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [3:0]  srcA, srcB, dstE, dstM, dbg_sel;
  logic [63:0] valE, valM, valA, valB, dbg_val;

  int checks = 0;
  int errors = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct {
    logic        rst;
    logic        we;
    logic [3:0]  de;
    logic [3:0]  dm;
    logic [63:0] ve;
    logic [63:0] vm;
    logic [3:0]  sa;
    logic [3:0]  sb;
    logic [3:0]  ds;
    logic [63:0] ea;
    logic [63:0] eb;
    logic [63:0] ed;
  } vec_t;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] d;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[10];

  register_file dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .srcA    (srcA),
    .srcB    (srcB),
    .dstE    (dstE),
    .dstM    (dstM),
    .valE    (valE),
    .valM    (valM),
    .valA    (valA),
    .valB    (valB),
    .dbg_sel (dbg_sel),
    .dbg_val (dbg_val)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one output value against its expected value.
  task automatic compareVal(input string label, input string port,
                            input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s %s: got %h expected %h", label, port, act, exp);
    end
  endtask

  task automatic pushExpect(input logic [63:0] a, input logic [63:0] b,
                            input logic [63:0] d);
    exp_t e;
    e.a = a;
    e.b = b;
    e.d = d;
    sb_q.push_back(e);
  endtask

  // Pop the oldest expectation and compare it with the current outputs.
  task automatic checkOutput(input string label);
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s scoreboard: got empty queue expected an entry", label);
    end else begin
      checks--;
      e = sb_q.pop_front();
      compareVal(label, "valA", valA, e.a);
      compareVal(label, "valB", valB, e.b);
      compareVal(label, "dbg_val", dbg_val, e.d);
    end
  endtask

  task automatic idleInputs();
    reset = 1'b0;
    wr_en = 1'b0;
    dstE  = 4'hF;
    dstM  = 4'hF;
  endtask

  // Drive one vector at negedge and let it commit at posedge. Then release
  // the write controls and check the post-edge reads.
  task automatic applyStimulus(input vec_t v, input string label);
    @(negedge clk);
    reset   = v.rst;
    wr_en   = v.we;
    dstE    = v.de;
    dstM    = v.dm;
    valE    = v.ve;
    valM    = v.vm;
    srcA    = v.sa;
    srcB    = v.sb;
    dbg_sel = v.ds;
    pushExpect(v.ea, v.eb, v.ed);
    @(posedge clk);
    #1;
    idleInputs();
    #1;
    checkOutput(label);
  endtask

  // Read-only check taken mid-cycle with no write pending.
  task automatic readCheck(input logic [3:0] sa, input logic [3:0] sb,
                           input logic [3:0] ds, input logic [63:0] ea,
                           input logic [63:0] eb, input logic [63:0] ed,
                           input string label);
    @(negedge clk);
    idleInputs();
    srcA    = sa;
    srcB    = sb;
    dbg_sel = ds;
    pushExpect(ea, eb, ed);
    #2;
    checkOutput(label);
  endtask

  task automatic writeCycle(input logic [3:0] de, input logic [63:0] ve);
    @(negedge clk);
    reset = 1'b0;
    wr_en = 1'b1;
    dstE  = de;
    dstM  = 4'hF;
    valE  = ve;
    @(posedge clk);
    #1;
    idleInputs();
  endtask

  initial begin
    reset   = 1'b1;
    wr_en   = 1'b0;
    dstE    = 4'hF;
    dstM    = 4'hF;
    valE    = '0;
    valM    = '0;
    srcA    = 4'd0;
    srcB    = 4'd0;
    dbg_sel = 4'd0;

    // rst we de dm ve vm sa sb ds | ea eb ed
    vecs[0] = '{1'b1, 1'b1, 4'd3, 4'hF, 64'h77, 64'h0, 4'd3, 4'd14, 4'd7, 64'h0, 64'h0, 64'h0};
    vecs[1] = '{1'b1, 1'b0, 4'hF, 4'hF, 64'h0, 64'h0, 4'd0, 4'd3, 4'd14, 64'h0, 64'h0, 64'h0};
    vecs[2] = '{1'b0, 1'b1, 4'd3, 4'hF, 64'h1122334455667788, 64'h0, 4'd3, 4'd4, 4'd3,
                64'h1122334455667788, 64'h0, 64'h1122334455667788};
    vecs[3] = '{1'b0, 1'b1, 4'd4, 4'd4, 64'hA, 64'hB, 4'd4, 4'd3, 4'd4,
                64'hB, 64'h1122334455667788, 64'hB};
    vecs[4] = '{1'b0, 1'b1, 4'd2, 4'd5, 64'hA, 64'hB, 4'd2, 4'd5, 4'd4, 64'hA, 64'hB, 64'hB};
    vecs[5] = '{1'b0, 1'b1, 4'hF, 4'hF, 64'hFF, 64'hEE, 4'd2, 4'd5, 4'd3,
                64'hA, 64'hB, 64'h1122334455667788};
    vecs[6] = '{1'b0, 1'b0, 4'd1, 4'hF, 64'hFF, 64'h0, 4'd1, 4'hF, 4'd2, 64'h0, 64'h0, 64'hA};
    vecs[7] = '{1'b0, 1'b1, 4'd7, 4'hF, 64'h5, 64'h0, 4'hF, 4'd7, 4'hF, 64'h0, 64'h5, 64'h0};
    vecs[8] = '{1'b0, 1'b1, 4'hF, 4'd0, 64'h99, 64'hCAFE, 4'd0, 4'd7, 4'd14, 64'hCAFE, 64'h5, 64'h0};
    vecs[9] = '{1'b0, 1'b1, 4'd14, 4'hF, 64'hFFFFFFFFFFFFFFFF, 64'h0, 4'd14, 4'd0, 4'd14,
                64'hFFFFFFFFFFFFFFFF, 64'hCAFE, 64'hFFFFFFFFFFFFFFFF};

    // Vectors 0 and 1 hold reset for two cycles. After them every register reads zero.
    applyStimulus(vecs[0], "reset_0");
    applyStimulus(vecs[1], "reset_1");
    for (int id = 0; id < 15; id++) begin
      readCheck(4'(id), 4'(14 - id), 4'(id), 64'h0, 64'h0, 64'h0, "reset_sweep");
    end

    for (int i = 2; i < 10; i++) begin
      applyStimulus(vecs[i], $sformatf("vec_%0d", i));
    end

    // Same-cycle read and write on reg 7, which currently holds 5.
    @(negedge clk);
    reset = 1'b0; wr_en = 1'b1; dstE = 4'd7; dstM = 4'hF; valE = 64'h9;
    srcA = 4'd7; srcB = 4'd7; dbg_sel = 4'd7;
    pushExpect(BYPASS ? 64'h9 : 64'h5, BYPASS ? 64'h9 : 64'h5, BYPASS ? 64'h9 : 64'h5);
    #2;
    checkOutput("same_cycle_pre");
    @(posedge clk);
    #1;
    idleInputs();
    #1;
    pushExpect(64'h9, 64'h9, 64'h9);
    checkOutput("same_cycle_post");

    // Both ports target reg 7 in the same cycle. The M port has priority.
    @(negedge clk);
    wr_en = 1'b1; dstE = 4'd7; dstM = 4'd7; valE = 64'h11; valM = 64'h22;
    pushExpect(BYPASS ? 64'h22 : 64'h9, BYPASS ? 64'h22 : 64'h9, BYPASS ? 64'h22 : 64'h9);
    #2;
    checkOutput("conflict_pre");
    @(posedge clk);
    #1;
    idleInputs();
    #1;
    pushExpect(64'h22, 64'h22, 64'h22);
    checkOutput("conflict_post");

    // Fill every register with ID*0x101, then read them all back.
    for (int i = 0; i < 15; i++) begin
      writeCycle(4'(i), 64'(i) * 64'h101);
    end
    for (int i = 0; i < 15; i++) begin
      readCheck(4'(i), 4'(14 - i), 4'(i), 64'(i) * 64'h101, 64'(14 - i) * 64'h101,
                64'(i) * 64'h101, "fill");
    end

    // Reset mid-run while a write to reg 6 is in flight. Reset also blocks
    // forwarding, so the pre-edge read still shows the stored value.
    @(negedge clk);
    reset = 1'b1; wr_en = 1'b1; dstE = 4'd6; dstM = 4'hF; valE = 64'hDEAD;
    srcA = 4'd6; srcB = 4'd6; dbg_sel = 4'd6;
    pushExpect(64'h606, 64'h606, 64'h606);
    #2;
    checkOutput("midreset_pre");
    @(posedge clk);
    #1;
    idleInputs();
    for (int id = 0; id < 15; id++) begin
      readCheck(4'(id), 4'(14 - id), 4'(id), 64'h0, 64'h0, 64'h0, "midreset_sweep");
    end

    if (sb_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d leftover entries expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
